// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - 8-function combinational ALU with a save-enabled result register
module instruction_memory #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   opcode,
  output logic [OPW-1:0]   alu_sel,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out,
  input  logic             save,
  output logic [WIDTH-1:0] data_out
);

  localparam logic [OPW-1:0] OP_ADD = 3'b000;
  localparam logic [OPW-1:0] OP_SUB = 3'b001;
  localparam logic [OPW-1:0] OP_AND = 3'b010;
  localparam logic [OPW-1:0] OP_OR  = 3'b011;
  localparam logic [OPW-1:0] OP_XOR = 3'b100;
  localparam logic [OPW-1:0] OP_MUL = 3'b101;
  localparam logic [OPW-1:0] OP_DIV = 3'b110;
  localparam logic [OPW-1:0] OP_CMP = 3'b111;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_div_zero;
  logic [WIDTH-1:0]   w_divisor;
  logic [WIDTH-1:0]   w_quot;
  logic               w_eq;
  logic               w_gt;
  logic               w_lt;
  logic [WIDTH-1:0]   w_alu_out;
  logic               w_carry;
  logic [WIDTH-1:0]   r_data_out;

  assign alu_sel = opcode;

  // Widen by one bit so the top bit is the carry (add) or the borrow (sub).
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};
  assign w_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Divide by a forced 1 when b is zero so the divider never produces X;
  // the zero-divisor result is substituted in the mux below.
  assign w_div_zero = (b == '0);
  assign w_divisor  = w_div_zero ? WIDTH'(1) : b;
  assign w_quot     = a / w_divisor;

  assign w_eq = (a == b);
  assign w_gt = (a > b);
  assign w_lt = (a < b);

  // Function select: result and flag for the current opcode.
  always_comb begin
    w_alu_out = '0;
    w_carry   = 1'b0;
    case (opcode)
      OP_ADD: begin
        w_alu_out = w_sum[WIDTH-1:0];
        w_carry   = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_alu_out = w_diff[WIDTH-1:0];
        w_carry   = w_diff[WIDTH];
      end
      OP_AND: w_alu_out = a & b;
      OP_OR:  w_alu_out = a | b;
      OP_XOR: w_alu_out = a ^ b;
      OP_MUL: begin
        w_alu_out = w_prod[WIDTH-1:0];
        w_carry   = |w_prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        w_alu_out = w_div_zero ? '1 : w_quot;
        w_carry   = w_div_zero;
      end
      OP_CMP: w_alu_out = {{(WIDTH-3){1'b0}}, w_lt, w_gt, w_eq};
      default: begin
        w_alu_out = '0;
        w_carry   = 1'b0;
      end
    endcase
  end

  assign alu_out   = w_alu_out;
  assign carry_out = w_carry;

  // Result store: reset clears it and wins over save; otherwise save captures the ALU result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data_out <= '0;
    end else if (save) begin
      r_data_out <= w_alu_out;
    end
  end

  assign data_out = r_data_out;

endmodule

// File: tb/tb_instruction_memory.sv
// tb/tb_instruction_memory.sv - self-checking bench for instruction_memory
module tb_instruction_memory;

  logic       clk;
  logic       reset;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] opcode;
  logic [2:0] alu_sel;
  logic [7:0] alu_out;
  logic       carry_out;
  logic       save;
  logic [7:0] data_out;

  int checks;
  int errors;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] exp_out;
    logic       exp_c;
  } vec_t;

  vec_t vecs[13];

  instruction_memory #(.WIDTH(8), .OPW(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .carry_out (carry_out),
    .save      (save),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference ALU from plain integer arithmetic; returns {carry, result}.
  function automatic logic [8:0] ref_alu(input int x, input int y, input int op);
    int r;
    int c;
    logic [7:0] lx;
    logic [7:0] ly;
    lx = x[7:0];
    ly = y[7:0];
    r = 0;
    c = 0;
    case (op)
      0: begin r = x + y; c = (r > 255) ? 1 : 0; r = r % 256; end
      1: begin c = (x < y) ? 1 : 0; r = (x - y + 256) % 256; end
      2: r = int'(lx & ly);
      3: r = int'(lx | ly);
      4: r = int'(lx ^ ly);
      5: begin r = x * y; c = (r > 255) ? 1 : 0; r = r % 256; end
      6: begin
        if (y == 0) begin r = 255; c = 1; end
        else r = x / y;
      end
      default: r = (x == y) ? 1 : ((x > y) ? 2 : 4);
    endcase
    ref_alu = {c[0], r[7:0]};
  endfunction

  initial begin
    logic [8:0] m;
    logic [7:0] model_q;
    logic [7:0] held;

    checks = 0;
    errors = 0;

    vecs[0]  = '{8'h05, 8'h03, 3'b000, 8'h08, 1'b0};
    vecs[1]  = '{8'hCC, 8'hAA, 3'b001, 8'h22, 1'b0};
    vecs[2]  = '{8'h03, 8'h05, 3'b001, 8'hFE, 1'b1};
    vecs[3]  = '{8'h05, 8'h03, 3'b010, 8'h01, 1'b0};
    vecs[4]  = '{8'hCC, 8'hAA, 3'b011, 8'hEE, 1'b0};
    vecs[5]  = '{8'h05, 8'h03, 3'b100, 8'h06, 1'b0};
    vecs[6]  = '{8'hCC, 8'hAA, 3'b101, 8'h78, 1'b1};
    vecs[7]  = '{8'h05, 8'h03, 3'b110, 8'h01, 1'b0};
    vecs[8]  = '{8'h05, 8'h00, 3'b110, 8'hFF, 1'b1};
    vecs[9]  = '{8'hCC, 8'hAA, 3'b111, 8'h02, 1'b0};
    vecs[10] = '{8'h10, 8'h10, 3'b111, 8'h01, 1'b0};
    vecs[11] = '{8'h01, 8'h02, 3'b111, 8'h04, 1'b0};
    vecs[12] = '{8'hFF, 8'h01, 3'b000, 8'h00, 1'b1};

    // Reset with save high for two edges.
    reset = 1'b0; save = 1'b1; a = 8'h12; b = 8'h34; opcode = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data_out", int'(data_out), 0);

    // Directed table: combinational results, then the registered copy.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      reset = 1'b1; save = 1'b1;
      a = vecs[i].a; b = vecs[i].b; opcode = vecs[i].op;
      #1;
      chk($sformatf("vec%0d_alu_out", i), int'(alu_out), int'(vecs[i].exp_out));
      chk($sformatf("vec%0d_carry", i), int'(carry_out), int'(vecs[i].exp_c));
      chk($sformatf("vec%0d_alu_sel", i), int'(alu_sel), int'(vecs[i].op));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_data_out", i), int'(data_out), int'(vecs[i].exp_out));
    end

    // Store a known value, then hold it while the ALU inputs churn.
    @(negedge clk);
    a = 8'h05; b = 8'h03; opcode = 3'b000; save = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_setup", int'(data_out), 8'h08);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      save = 1'b0; a = 8'hA0 + 8'(i); b = 8'h11; opcode = 3'(i + 1);
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d_data_out", i), int'(data_out), 8'h08);
    end

    // Reset wins over save on the same edge.
    @(negedge clk);
    save = 1'b1; reset = 1'b0; a = 8'h40; b = 8'h02; opcode = 3'b000;
    @(posedge clk);
    #1;
    chk("priority_data_out", int'(data_out), 0);

    // Back-to-back saves: data_out trails alu_out by one cycle.
    @(negedge clk);
    reset = 1'b1; save = 1'b1; a = 8'h20; b = 8'h01; opcode = 3'b000;
    @(posedge clk);
    @(negedge clk);
    chk("stream0_data_out", int'(data_out), 8'h21);
    a = 8'h30; b = 8'h01; opcode = 3'b001;
    @(posedge clk);
    #1;
    chk("stream1_data_out", int'(data_out), 8'h2F);

    // Randomized run against the reference model.
    model_q = data_out;
    held = model_q;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      a = 8'($urandom_range(0, 255));
      b = (($urandom_range(0, 7)) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      if (($urandom_range(0, 7)) == 0) b = a;
      opcode = 3'($urandom_range(0, 7));
      save = 1'($urandom_range(0, 1));
      reset = (($urandom_range(0, 15)) == 0) ? 1'b0 : 1'b1;
      #1;
      m = ref_alu(int'(a), int'(b), int'(opcode));
      chk("rand_alu_out", int'(alu_out), int'(m[7:0]));
      chk("rand_carry", int'(carry_out), int'(m[8]));
      chk("rand_alu_sel", int'(alu_sel), int'(opcode));
      if (!reset) model_q = 8'h00;
      else if (save) model_q = m[7:0];
      @(posedge clk);
      #1;
      chk("rand_data_out", int'(data_out), int'(model_q));
    end
    held = model_q;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_memory.md
Name: instruction_memory

Overview:
- Single-cycle execute-and-store block for the 8-bit CPU.
- A combinational 8-function ALU operates on operands a/b selected by a 3-bit opcode.
- The ALU result and carry are visible immediately on alu_out and carry_out.
- When save is asserted, the result is latched into an output data register (data_out) on the clock edge, serving as the CPU's result/accumulator store.

Parameters:
- WIDTH, 8, operand/result data width (all behaviour below is for 8).
- OPW, 3, opcode width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset. 0 clears state on the next rising clk edge.
- a  input  8  operand A.
- b  input  8  operand B.
- opcode  input  3  operation select.
- alu_sel  output  3  combinational copy of opcode, driving the ALU function mux.
- alu_out  output  8  combinational ALU result.
- carry_out  output  1  combinational ALU flag (carry/borrow/overflow/div-by-zero).
- save  input  1  store-enable; latch alu_out into data_out on next rising edge.
- data_out  output  8  registered stored result.

Behaviour:
- alu_sel = opcode, purely combinational, no latency.
- ALU is purely combinational; alu_out and carry_out follow a, b and opcode in the same cycle and are unaffected by reset.
- Opcode map:
  - 000 ADD: {carry_out, alu_out} = a + b (9-bit sum).
  - 001 SUB: alu_out = (a - b) mod 256; carry_out = 1 iff a < b (borrow).
  - 010 AND: alu_out = a & b; carry_out = 0.
  - 011 OR: alu_out = a | b; carry_out = 0.
  - 100 XOR: alu_out = a ^ b; carry_out = 0.
  - 101 MUL: 16-bit product p = a * b (unsigned); alu_out = p[7:0]; carry_out = 1 iff p[15:8] != 0.
  - 110 DIV: alu_out = unsigned quotient a / b; carry_out = 0. If b == 0, alu_out = 8'hFF and carry_out = 1.
  - 111 CMP: unsigned compare. alu_out[0] = (a == b), alu_out[1] = (a > b), alu_out[2] = (a < b), alu_out[7:3] = 0. Exactly one of bits [2:0] is set. carry_out = 0.
- All arithmetic is unsigned. No X on outputs for any input combination.
- data_out register, evaluated at each rising clk:
  - reset == 0: data_out <= 8'h00. Reset has priority over save.
  - else if save == 1: data_out <= alu_out of the current cycle.
  - else: data_out holds its value.
- Latency: data_out reflects a saved result one clock after the edge where save is sampled high.
- With save held high continuously, data_out tracks alu_out with a 1-cycle delay.
- Inputs changing mid-cycle affect only the value sampled at the edge.
- Before the first reset, data_out is undefined; the bench must apply reset first.
- The reset value of data_out is 8'h00. alu_sel, alu_out and carry_out have no reset value (combinational).

Test Plan:
1. Reset: reset=0 for 2 edges with save=1 → data_out = 8'h00. Release reset (reset=1).
2. ADD/SUB, save=1, one edge each:
   - a=8'h05, b=8'h03, op=000 → alu_out=8'h08, carry=0, data_out=8'h08.
   - a=8'hCC, b=8'hAA, op=001 → alu_out=8'h22, carry=0.
   - a=8'h03, b=8'h05, op=001 → alu_out=8'hFE, carry=1.
3. Logic ops:
   - a=8'h05, b=8'h03, op=010 → 8'h01.
   - a=8'hCC, b=8'hAA, op=011 → 8'hEE.
   - a=8'h05, b=8'h03, op=100 → 8'h06.
   - carry=0 in all cases; data_out follows one edge later; alu_sel equals op.
4. MUL/DIV:
   - a=8'hCC, b=8'hAA, op=101 → alu_out=8'h78, carry=1.
   - a=8'h05, b=8'h03, op=110 → alu_out=8'h01, carry=0.
   - a=8'h05, b=8'h00, op=110 → alu_out=8'hFF, carry=1.
5. CMP, op=111:
   - a=8'hCC, b=8'hAA → 8'h02.
   - a=b=8'h10 → 8'h01.
   - a=8'h01, b=8'h02 → 8'h04.
6. Hold/priority:
   - save=0 with changing ops → data_out unchanged.
   - save=1 with reset=0 at the same edge → data_out = 8'h00.
